// File: rtl/ibex_pkg.sv
// rtl/ibex_pkg.sv - shared types and helpers for the multi-entry writeback queue
//
// Purpose: writeback instruction type, queue entry layout and the age-order
// index helpers shared by the queue and its forwarding lookup.
// Ports: none (package).

package ibex_pkg;

  // Entry data is sized for the widest FP register file so that one entry
  // layout serves both FpuWidth=32 and FpuWidth=64 builds.
  localparam int FPU_WIDTH_MAX = 64;

  typedef enum logic [1:0] {
    WB_INSTR_LOAD  = 2'd0,
    WB_INSTR_STORE = 2'd1,
    WB_INSTR_OTHER = 2'd2
  } wb_instr_type_e;

  typedef struct packed {
    logic                     valid;
    wb_instr_type_e           instr_type;
    logic [31:0]              pc;
    logic                     compressed;
    logic                     perf;
    logic [4:0]               waddr;
    logic                     rf_we;
    logic                     fp_we;
    logic                     fp_load;
    logic [FPU_WIDTH_MAX-1:0] data;
    logic                     done;
    logic                     err;
  } wb_entry_t;

  // Physical slot of the entry that is 'age' positions younger than head.
  // Depth need not be a power of two, so wrap explicitly.
  function automatic int wb_age_idx(input int head, input int age, input int depth);
    int slot;
    slot = head + age;
    if (slot >= depth) begin
      slot = slot - depth;
    end
    return slot;
  endfunction

  // An entry targets the integer RF either explicitly or as an integer load.
  function automatic logic wb_writes_int(input wb_entry_t e);
    return e.rf_we | ((e.instr_type == WB_INSTR_LOAD) & ~e.fp_load);
  endfunction

endpackage

// File: rtl/ibex_wb_fwd_lookup.sv
// rtl/ibex_wb_fwd_lookup.sv - youngest-match forwarding and load-hazard search for one read port
//
// Purpose: scan the queue in age order and report whether the youngest entry
// writing 'raddr' into the integer RF can forward its data, or is a load whose
// data has not arrived yet.
// Ports:
//   entries    in   queue storage (all slots)
//   head       in   slot of the oldest entry
//   raddr      in   ID read address (x0 never matches)
//   fwd_valid  out  forwarding data available
//   fwd_data   out  forwarded data (0 when fwd_valid=0)
//   hazard     out  youngest match is a load still awaiting its response

module ibex_wb_fwd_lookup
  import ibex_pkg::*;
#(
  parameter int Depth = 2,
  parameter int PtrW  = 1
) (
  input  wb_entry_t       entries [Depth],
  input  logic [PtrW-1:0] head,
  input  logic [4:0]      raddr,
  output logic            fwd_valid,
  output logic [31:0]     fwd_data,
  output logic            hazard
);

  logic      hit;
  wb_entry_t hit_entry;
  wb_entry_t cur;
  logic      hit_is_load;
  logic      unused_fields;

  // Walk oldest to youngest; a later match overwrites an earlier one, so the
  // youngest writer shadows any older ones.
  always_comb begin
    hit           = 1'b0;
    hit_entry     = '0;
    cur           = '0;
    unused_fields = 1'b0;
    for (int i = 0; i < Depth; i++) begin
      cur = entries[PtrW'(wb_age_idx(int'(head), i, Depth))];
      unused_fields = unused_fields ^ (^{cur.pc, cur.compressed, cur.perf, cur.fp_we,
                                         cur.data[FPU_WIDTH_MAX-1:32]});
      if (cur.valid && (raddr != 5'd0) && (cur.waddr == raddr) && wb_writes_int(cur)) begin
        hit       = 1'b1;
        hit_entry = cur;
      end
    end
  end

  assign hit_is_load = (hit_entry.instr_type == WB_INSTR_LOAD);

  // A load that completed with an error never writes the RF, so it neither
  // forwards nor stalls; it still shadows older writers of the same register.
  always_comb begin
    fwd_valid = 1'b0;
    fwd_data  = '0;
    hazard    = 1'b0;
    if (hit) begin
      if (!hit_is_load || (hit_entry.done && !hit_entry.err)) begin
        fwd_valid = 1'b1;
        fwd_data  = hit_entry.data[31:0];
      end else if (!hit_entry.done) begin
        hazard = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ibex_wb_queue.sv
// rtl/ibex_wb_queue.sv - multi-entry in-order writeback queue with out-of-place LSU completion
//
// Purpose: holds up to Depth instructions between ID/EX and the register
// files. LSU responses complete the oldest pending load/store wherever it sits;
// the head retires in order, one per cycle, writing the integer or FP RF.
// Ports:
//   clk_i, rst_i                       clock, synchronous active-high reset
//   en_wb_i .. fp_load_i               enqueue interface from ID/EX
//   lsu_resp_valid_i/err_i, rf_wdata_lsu_i   LSU response
//   rf_raddr_a_i/b_i                   ID read addresses
//   ready_wb_o                         queue accepts an instruction this cycle
//   fwd_*, hazard_*                    per-port forwarding / load hazard
//   outstanding_load/store_wb_o        pending LSU work in the queue
//   pc_wb_o, instr_done_wb_o, perf_*   head PC and retire reporting
//   rf_*_wb_o, fp_rf_*_wb_o            integer / FP write ports
//   occupancy_o                        valid entry count

module ibex_wb_queue
  import ibex_pkg::*;
#(
  parameter int   Depth    = 2,
  parameter bit   FpuEn    = 1'b1,
  parameter int   FpuWidth = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         en_wb_i,
  input  logic [1:0]                   instr_type_wb_i,
  input  logic [31:0]                  pc_id_i,
  input  logic                         instr_is_compressed_id_i,
  input  logic                         instr_perf_count_id_i,
  input  logic [4:0]                   rf_waddr_id_i,
  input  logic [31:0]                  rf_wdata_id_i,
  input  logic                         rf_we_id_i,
  input  logic                         fp_rf_we_id_i,
  input  logic [FpuWidth-1:0]          fp_rf_wdata_id_i,
  input  logic                         fp_load_i,
  input  logic                         lsu_resp_valid_i,
  input  logic                         lsu_resp_err_i,
  input  logic [31:0]                  rf_wdata_lsu_i,
  input  logic [4:0]                   rf_raddr_a_i,
  input  logic [4:0]                   rf_raddr_b_i,
  output logic                         ready_wb_o,
  output logic                         fwd_valid_a_o,
  output logic                         fwd_valid_b_o,
  output logic [31:0]                  fwd_data_a_o,
  output logic [31:0]                  fwd_data_b_o,
  output logic                         hazard_a_o,
  output logic                         hazard_b_o,
  output logic                         outstanding_load_wb_o,
  output logic                         outstanding_store_wb_o,
  output logic [31:0]                  pc_wb_o,
  output logic                         instr_done_wb_o,
  output logic                         perf_instr_ret_wb_o,
  output logic                         perf_instr_ret_compressed_wb_o,
  output logic                         rf_we_wb_o,
  output logic [4:0]                   rf_waddr_wb_o,
  output logic [31:0]                  rf_wdata_wb_o,
  output logic                         fp_rf_we_wb_o,
  output logic [4:0]                   fp_rf_waddr_wb_o,
  output logic [FpuWidth-1:0]          fp_rf_wdata_wb_o,
  output logic [$clog2(Depth+1)-1:0]   occupancy_o
);

  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntW = $clog2(Depth + 1);

  wb_entry_t       entries_q [Depth];
  logic [PtrW-1:0] head_q;
  logic [PtrW-1:0] tail_q;
  logic [CntW-1:0] count_q;

  wb_entry_t       head_e;
  wb_entry_t       new_entry;
  wb_entry_t       scan_e;
  logic            resp_found;
  logic [PtrW-1:0] resp_idx;
  logic            resp_fire;
  logic            head_is_target;
  logic            head_is_load;
  logic            retire;
  logic            enq;
  logic            ret_err;
  logic [FPU_WIDTH_MAX-1:0] ret_data;
  logic            int_we;
  logic            fp_we;
  logic            unused_data;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign head_e = entries_q[head_q];

  // Oldest pending load/store: scan youngest to oldest so the oldest hit wins.
  always_comb begin
    resp_found = 1'b0;
    resp_idx   = '0;
    scan_e     = '0;
    for (int i = Depth - 1; i >= 0; i--) begin
      scan_e = entries_q[PtrW'(wb_age_idx(int'(head_q), i, Depth))];
      if (scan_e.valid && (scan_e.instr_type != WB_INSTR_OTHER) && !scan_e.done) begin
        resp_found = 1'b1;
        resp_idx   = PtrW'(wb_age_idx(int'(head_q), i, Depth));
      end
    end
  end

  assign resp_fire      = lsu_resp_valid_i & resp_found;
  assign head_is_target = resp_fire & (resp_idx == head_q);
  assign head_is_load   = (head_e.instr_type == WB_INSTR_LOAD);
  assign retire         = head_e.valid & (head_e.done | head_is_target);

  // When the head completes in this same cycle its stored fields are stale;
  // take error and load data straight from the LSU.
  assign ret_err  = head_is_target ? lsu_resp_err_i : head_e.err;
  assign ret_data = (head_is_target && head_is_load) ? {32'b0, rf_wdata_lsu_i} : head_e.data;

  assign ready_wb_o = (count_q < CntW'(Depth)) | retire;
  assign enq        = en_wb_i & ready_wb_o;

  always_comb begin
    new_entry            = '0;
    new_entry.valid      = 1'b1;
    new_entry.instr_type = wb_instr_type_e'(instr_type_wb_i);
    new_entry.pc         = pc_id_i;
    new_entry.compressed = instr_is_compressed_id_i;
    new_entry.perf       = instr_perf_count_id_i;
    new_entry.waddr      = rf_waddr_id_i;
    new_entry.rf_we      = rf_we_id_i;
    new_entry.fp_we      = fp_rf_we_id_i & FpuEn;
    new_entry.fp_load    = fp_load_i;
    new_entry.done       = (instr_type_wb_i == WB_INSTR_OTHER);
    if (fp_rf_we_id_i && FpuEn) begin
      new_entry.data[FpuWidth-1:0] = fp_rf_wdata_id_i;
    end else begin
      new_entry.data[31:0] = rf_wdata_id_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < Depth; i++) begin
        entries_q[i].valid <= 1'b0;
        entries_q[i].done  <= 1'b0;
      end
    end else begin
      assert (!(lsu_resp_valid_i && !resp_found));
      if (resp_fire) begin
        entries_q[resp_idx].done <= 1'b1;
        entries_q[resp_idx].err  <= lsu_resp_err_i;
        if (entries_q[resp_idx].instr_type == WB_INSTR_LOAD) begin
          entries_q[resp_idx].data <= {32'b0, rf_wdata_lsu_i};
        end
      end
      if (retire) begin
        entries_q[head_q].valid <= 1'b0;
        entries_q[head_q].done  <= 1'b0;
        head_q                  <= ptr_inc(head_q);
      end
      // Last so that a full-queue enqueue into the just-retired slot wins.
      if (enq) begin
        entries_q[tail_q] <= new_entry;
        tail_q            <= ptr_inc(tail_q);
      end
      count_q <= count_q + CntW'(enq) - CntW'(retire);
    end
  end

  assign int_we = head_e.rf_we | (head_is_load & ~head_e.fp_load & ~ret_err);
  assign fp_we  = head_e.fp_we | (head_is_load & head_e.fp_load & ~ret_err);

  assign instr_done_wb_o                = retire;
  assign pc_wb_o                        = head_e.valid ? head_e.pc : 32'b0;
  assign perf_instr_ret_wb_o            = retire & head_e.perf & ~ret_err;
  assign perf_instr_ret_compressed_wb_o = retire & head_e.perf & ~ret_err & head_e.compressed;
  assign rf_we_wb_o                     = retire & int_we;
  assign rf_waddr_wb_o                  = retire ? head_e.waddr : 5'b0;
  assign rf_wdata_wb_o                  = retire ? ret_data[31:0] : 32'b0;
  assign fp_rf_we_wb_o                  = FpuEn & retire & fp_we;
  assign fp_rf_waddr_wb_o               = (FpuEn && retire) ? head_e.waddr : 5'b0;
  assign fp_rf_wdata_wb_o               = (FpuEn && retire) ? ret_data[FpuWidth-1:0] : '0;
  assign occupancy_o                    = count_q;
  assign unused_data                    = ^ret_data;

  always_comb begin
    outstanding_load_wb_o  = 1'b0;
    outstanding_store_wb_o = 1'b0;
    for (int i = 0; i < Depth; i++) begin
      if (entries_q[i].valid && !entries_q[i].done) begin
        if (entries_q[i].instr_type == WB_INSTR_LOAD) begin
          outstanding_load_wb_o = 1'b1;
        end
        if (entries_q[i].instr_type == WB_INSTR_STORE) begin
          outstanding_store_wb_o = 1'b1;
        end
      end
    end
  end

  ibex_wb_fwd_lookup #(
    .Depth (Depth),
    .PtrW  (PtrW)
  ) u_fwd_a (
    .entries   (entries_q),
    .head      (head_q),
    .raddr     (rf_raddr_a_i),
    .fwd_valid (fwd_valid_a_o),
    .fwd_data  (fwd_data_a_o),
    .hazard    (hazard_a_o)
  );

  ibex_wb_fwd_lookup #(
    .Depth (Depth),
    .PtrW  (PtrW)
  ) u_fwd_b (
    .entries   (entries_q),
    .head      (head_q),
    .raddr     (rf_raddr_b_i),
    .fwd_valid (fwd_valid_b_o),
    .fwd_data  (fwd_data_b_o),
    .hazard    (hazard_b_o)
  );

endmodule

// File: tb/tb_ibex_wb_queue.sv
// tb/tb_ibex_wb_queue.sv - directed self-checking bench for ibex_wb_queue (Depth=2)

module tb_ibex_wb_queue;
  import ibex_pkg::*;

  localparam logic [1:0] LD = WB_INSTR_LOAD;
  localparam logic [1:0] ST = WB_INSTR_STORE;
  localparam logic [1:0] OT = WB_INSTR_OTHER;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [1:0]  itype;
  logic [31:0] pc;
  logic        comp;
  logic        perf;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        we;
  logic        fp_we_in;
  logic [31:0] fp_wdata_in;
  logic        fp_load;
  logic        resp_v;
  logic        resp_err;
  logic [31:0] lsu_data;
  logic [4:0]  raddr_a;
  logic [4:0]  raddr_b;

  logic        ready;
  logic        fwd_valid_a, fwd_valid_b;
  logic [31:0] fwd_data_a, fwd_data_b;
  logic        hazard_a, hazard_b;
  logic        out_ld, out_st;
  logic [31:0] pc_wb;
  logic        done_wb;
  logic        perf_ret, perf_ret_c;
  logic        rf_we_wb;
  logic [4:0]  rf_waddr_wb;
  logic [31:0] rf_wdata_wb;
  logic        fp_we_wb;
  logic [4:0]  fp_waddr_wb;
  logic [31:0] fp_wdata_wb;
  logic [1:0]  occ;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ibex_wb_queue #(
    .Depth    (2),
    .FpuEn    (1'b1),
    .FpuWidth (32)
  ) dut (
    .clk_i                          (clk),
    .rst_i                          (rst),
    .en_wb_i                        (en),
    .instr_type_wb_i                (itype),
    .pc_id_i                        (pc),
    .instr_is_compressed_id_i       (comp),
    .instr_perf_count_id_i          (perf),
    .rf_waddr_id_i                  (waddr),
    .rf_wdata_id_i                  (wdata),
    .rf_we_id_i                     (we),
    .fp_rf_we_id_i                  (fp_we_in),
    .fp_rf_wdata_id_i               (fp_wdata_in),
    .fp_load_i                      (fp_load),
    .lsu_resp_valid_i               (resp_v),
    .lsu_resp_err_i                 (resp_err),
    .rf_wdata_lsu_i                 (lsu_data),
    .rf_raddr_a_i                   (raddr_a),
    .rf_raddr_b_i                   (raddr_b),
    .ready_wb_o                     (ready),
    .fwd_valid_a_o                  (fwd_valid_a),
    .fwd_valid_b_o                  (fwd_valid_b),
    .fwd_data_a_o                   (fwd_data_a),
    .fwd_data_b_o                   (fwd_data_b),
    .hazard_a_o                     (hazard_a),
    .hazard_b_o                     (hazard_b),
    .outstanding_load_wb_o          (out_ld),
    .outstanding_store_wb_o         (out_st),
    .pc_wb_o                        (pc_wb),
    .instr_done_wb_o                (done_wb),
    .perf_instr_ret_wb_o            (perf_ret),
    .perf_instr_ret_compressed_wb_o (perf_ret_c),
    .rf_we_wb_o                     (rf_we_wb),
    .rf_waddr_wb_o                  (rf_waddr_wb),
    .rf_wdata_wb_o                  (rf_wdata_wb),
    .fp_rf_we_wb_o                  (fp_we_wb),
    .fp_rf_waddr_wb_o               (fp_waddr_wb),
    .fp_rf_wdata_wb_o               (fp_wdata_wb),
    .occupancy_o                    (occ)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    en = 1'b0; itype = OT; pc = '0; comp = 1'b0; perf = 1'b0;
    waddr = '0; wdata = '0; we = 1'b0; fp_we_in = 1'b0; fp_wdata_in = '0;
    fp_load = 1'b0; resp_v = 1'b0; resp_err = 1'b0; lsu_data = '0;
  endtask

  task automatic enq(input logic [1:0] t, input logic [4:0] rd, input logic [31:0] d,
                     input logic rwe, input logic fpl, input logic [31:0] p,
                     input logic pf, input logic c);
    en = 1'b1; itype = t; waddr = rd; wdata = d; we = rwe; fp_load = fpl;
    pc = p; perf = pf; comp = c;
  endtask

  task automatic cyc_end();
    @(posedge clk);
    #1;
    idle();
  endtask

  initial begin
    idle();
    rst = 1'b1; raddr_a = '0; raddr_b = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst_occ", occ, 0);
    chk("rst_ready", ready, 1);
    chk("rst_pc", pc_wb, 0);
    chk("rst_rf_we", rf_we_wb, 0);
    chk("rst_out_ld", out_ld, 0);
    cyc_end();

    // OTHER x5 retires the cycle after enqueue; LOAD x6 stalls readers of x6
    enq(OT, 5'd5, 32'hA5, 1'b1, 1'b0, 32'h100, 1'b1, 1'b0);
    @(negedge clk);
    chk("t1_no_early_ret", done_wb, 0);
    cyc_end();
    enq(LD, 5'd6, 32'h0, 1'b0, 1'b0, 32'h104, 1'b1, 1'b0);
    raddr_a = 5'd5;
    @(negedge clk);
    chk("t1_x5_we", rf_we_wb, 1);
    chk("t1_x5_addr", rf_waddr_wb, 5);
    chk("t1_x5_data", rf_wdata_wb, 32'hA5);
    chk("t1_occ", occ, 1);
    chk("t1_pc", pc_wb, 32'h100);
    chk("t1_fwd_a5_v", fwd_valid_a, 1);
    chk("t1_fwd_a5_d", fwd_data_a, 32'hA5);
    cyc_end();
    raddr_a = 5'd6;
    @(negedge clk);
    chk("t1_occ_ld", occ, 1);
    chk("t1_hazard", hazard_a, 1);
    chk("t1_fwd_a6_v", fwd_valid_a, 0);
    chk("t1_out_ld", out_ld, 1);
    chk("t1_no_we", rf_we_wb, 0);
    chk("t1_pc_ld", pc_wb, 32'h104);
    cyc_end();
    resp_v = 1'b1; lsu_data = 32'h1234;
    @(negedge clk);
    chk("t1_x6_we", rf_we_wb, 1);
    chk("t1_x6_addr", rf_waddr_wb, 6);
    chk("t1_x6_data", rf_wdata_wb, 32'h1234);
    chk("t1_x6_done", done_wb, 1);
    cyc_end();
    @(negedge clk);
    chk("t1_empty", occ, 0);
    chk("t1_hazard_clr", hazard_a, 0);
    chk("t1_out_ld_clr", out_ld, 0);
    cyc_end();

    // full queue blocks; a bypassed head response frees a slot the same cycle
    enq(LD, 5'd1, 32'h0, 1'b0, 1'b0, 32'h300, 1'b1, 1'b0);
    @(negedge clk);
    chk("t2_ready0", ready, 1);
    cyc_end();
    enq(OT, 5'd2, 32'h7, 1'b1, 1'b0, 32'h304, 1'b1, 1'b0);
    @(negedge clk);
    chk("t2_ready1", ready, 1);
    chk("t2_blocked", done_wb, 0);
    cyc_end();
    enq(OT, 5'd3, 32'h9, 1'b1, 1'b0, 32'h308, 1'b1, 1'b0);
    @(negedge clk);
    chk("t2_full_ready", ready, 0);
    chk("t2_full_occ", occ, 2);
    @(posedge clk);
    #1;
    resp_v = 1'b1; lsu_data = 32'hBEEF;
    @(negedge clk);
    chk("t2_bypass_ready", ready, 1);
    chk("t2_x1_we", rf_we_wb, 1);
    chk("t2_x1_addr", rf_waddr_wb, 1);
    chk("t2_x1_data", rf_wdata_wb, 32'hBEEF);
    cyc_end();
    @(negedge clk);
    chk("t2_occ_after", occ, 2);
    chk("t2_x2_addr", rf_waddr_wb, 2);
    chk("t2_x2_data", rf_wdata_wb, 32'h7);
    cyc_end();
    @(negedge clk);
    chk("t2_x3_addr", rf_waddr_wb, 3);
    chk("t2_x3_data", rf_wdata_wb, 32'h9);
    cyc_end();
    @(negedge clk);
    chk("t2_empty", occ, 0);
    cyc_end();

    // store with bus error, then a compressed load
    enq(ST, 5'd0, 32'h0, 1'b0, 1'b0, 32'h400, 1'b1, 1'b0);
    @(negedge clk);
    cyc_end();
    enq(LD, 5'd4, 32'h0, 1'b0, 1'b0, 32'h404, 1'b1, 1'b1);
    @(negedge clk);
    chk("t3_out_st", out_st, 1);
    chk("t3_blocked", done_wb, 0);
    cyc_end();
    resp_v = 1'b1; resp_err = 1'b1;
    @(negedge clk);
    chk("t3_st_done", done_wb, 1);
    chk("t3_st_perf", perf_ret, 0);
    chk("t3_st_we", rf_we_wb, 0);
    chk("t3_st_pc", pc_wb, 32'h400);
    cyc_end();
    resp_v = 1'b1; lsu_data = 32'h55;
    @(negedge clk);
    chk("t3_x4_we", rf_we_wb, 1);
    chk("t3_x4_addr", rf_waddr_wb, 4);
    chk("t3_x4_data", rf_wdata_wb, 32'h55);
    chk("t3_x4_perf", perf_ret, 1);
    chk("t3_x4_perf_c", perf_ret_c, 1);
    cyc_end();

    // FP load
    enq(LD, 5'd3, 32'h0, 1'b0, 1'b1, 32'h500, 1'b1, 1'b0);
    @(negedge clk);
    cyc_end();
    resp_v = 1'b1; lsu_data = 32'h3F800000;
    @(negedge clk);
    chk("t4_fp_we", fp_we_wb, 1);
    chk("t4_fp_addr", fp_waddr_wb, 3);
    chk("t4_fp_data", fp_wdata_wb, 32'h3F800000);
    chk("t4_int_we", rf_we_wb, 0);
    cyc_end();

    // two writers of x7: younger OTHER shadows the pending older load
    raddr_a = 5'd0; raddr_b = 5'd7;
    enq(LD, 5'd7, 32'h0, 1'b0, 1'b0, 32'h600, 1'b1, 1'b0);
    @(negedge clk);
    cyc_end();
    enq(OT, 5'd7, 32'h22, 1'b1, 1'b0, 32'h604, 1'b1, 1'b0);
    @(negedge clk);
    chk("t5_hazard_b", hazard_b, 1);
    chk("t5_fwd_b_v0", fwd_valid_b, 0);
    cyc_end();
    @(negedge clk);
    chk("t5_fwd_b_v", fwd_valid_b, 1);
    chk("t5_fwd_b_d", fwd_data_b, 32'h22);
    chk("t5_hazard_b_shadow", hazard_b, 0);
    chk("t5_fwd_a_x0", fwd_valid_a, 0);
    raddr_b = 5'd0;
    #1;
    chk("t5_fwd_b_x0", fwd_valid_b, 0);
    raddr_b = 5'd7;
    cyc_end();
    resp_v = 1'b1; lsu_data = 32'h11;
    @(negedge clk);
    chk("t5_x7_first", rf_wdata_wb, 32'h11);
    chk("t5_fwd_still_young", fwd_data_b, 32'h22);
    cyc_end();
    @(negedge clk);
    chk("t5_x7_second_addr", rf_waddr_wb, 7);
    chk("t5_x7_second", rf_wdata_wb, 32'h22);
    cyc_end();

    // reset drops in-flight loads and overrides a same-cycle response
    enq(LD, 5'd8, 32'h0, 1'b0, 1'b0, 32'h700, 1'b1, 1'b0);
    @(negedge clk);
    cyc_end();
    enq(LD, 5'd9, 32'h0, 1'b0, 1'b0, 32'h704, 1'b1, 1'b0);
    @(negedge clk);
    cyc_end();
    @(negedge clk);
    chk("t6_occ2", occ, 2);
    chk("t6_out_ld", out_ld, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    resp_v = 1'b1; lsu_data = 32'hDEAD;
    @(negedge clk);
    chk("t6_rst_resp_we", rf_we_wb, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle();
    @(negedge clk);
    chk("t6_occ0", occ, 0);
    chk("t6_out_ld_clr", out_ld, 0);
    chk("t6_we0", rf_we_wb, 0);
    chk("t6_ready", ready, 1);
    chk("t6_pc0", pc_wb, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ibex_wb_queue.md
Name: ibex_wb_queue

Overview:
- Multi-entry writeback stage between ID/EX and the integer/FP register files.
- Generalises the single-slot writeback to `Depth` in-flight instructions, so several loads/stores can be outstanding while ALU results queue behind them.
- LSU responses complete the oldest outstanding load/store, which may be anywhere in the queue. Retirement is strictly in order, one instruction per cycle.
- Provides per-read-port forwarding and load-hazard detection for ID.

Parameters:
- Depth, 2, number of queue entries; any value >= 1 (Depth=1 behaves as the legacy single-slot stage).
- FpuEn, 1'b1, instantiate FP writeback path; when 0, all fp_* outputs are tied to 0.
- FpuWidth, 32, FP register data width (32 or 64).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- en_wb_i  in  1  enqueue an instruction from ID/EX (only acted on when ready_wb_o=1)
- instr_type_wb_i  in  2  wb_instr_type_e: LOAD/STORE/OTHER
- pc_id_i  in  32  instruction PC
- instr_is_compressed_id_i  in  1  compressed flag
- instr_perf_count_id_i  in  1  count toward retire counters
- rf_waddr_id_i  in  5  destination register
- rf_wdata_id_i  in  32  ID/EX integer result
- rf_we_id_i  in  1  integer write enable
- fp_rf_we_id_i  in  1  FP write enable
- fp_rf_wdata_id_i  in  FpuWidth  FP result
- fp_load_i  in  1  load targets the FP RF
- lsu_resp_valid_i  in  1  LSU response for the oldest outstanding load/store
- lsu_resp_err_i  in  1  response is a bus error
- rf_wdata_lsu_i  in  32  load data
- rf_raddr_a_i, rf_raddr_b_i  in  5 each  ID read addresses for hazard lookup
- ready_wb_o  out  1  queue can accept an instruction this cycle
- fwd_valid_a_o, fwd_valid_b_o  out  1 each  forwarding data available
- fwd_data_a_o, fwd_data_b_o  out  32 each  forwarded data
- hazard_a_o, hazard_b_o  out  1 each  matching load still awaiting data; ID must stall
- outstanding_load_wb_o, outstanding_store_wb_o  out  1 each  any queued load / store without a response
- pc_wb_o  out  32  head-entry PC (0 when empty)
- instr_done_wb_o  out  1  head retires this cycle
- perf_instr_ret_wb_o, perf_instr_ret_compressed_wb_o  out  1 each  retire counters
- rf_we_wb_o, rf_waddr_wb_o, rf_wdata_wb_o  out  1/5/32  integer RF write port
- fp_rf_we_wb_o, fp_rf_waddr_wb_o, fp_rf_wdata_wb_o  out  1/5/FpuWidth  FP RF write port
- occupancy_o  out  $clog2(Depth+1)  valid entry count

Behaviour:
- Storage is a circular buffer with head pointer, tail pointer and count. Pointers wrap at Depth-1 (no power-of-two requirement).
- Each entry holds: valid, type, pc, compressed, perf, waddr, rf_we, fp_we, fp_load, data (FpuWidth wide), done, err.
- Enqueue:
  - Occurs when en_wb_i & ready_wb_o; the entry is written at the tail.
  - OTHER entries are enqueued with done=1.
  - LOAD/STORE entries are enqueued with done=0.
- LSU response:
  - lsu_resp_valid_i marks the oldest entry with type!=OTHER and done=0 as done.
  - For a load, rf_wdata_lsu_i is stored in that entry's data; err stores lsu_resp_err_i.
  - Response with no such entry: ignored, and an assertion fires.
- Retire:
  - Head retires when valid and done, or when it is the response target in the same cycle (bypass: data/err are taken from the LSU inputs). Zero-cycle for OTHER at the head.
  - Integer write on retire: rf_we_wb_o = rf_we | (LOAD & ~fp_load & ~err).
  - FP write on retire: fp_rf_we_wb_o = fp_we | (LOAD & fp_load & ~err).
  - Both write ports output 0 when no retire occurs.
- Perf: perf_instr_ret_wb_o = retire & perf & ~err; the compressed variant additionally requires the compressed flag.
- Ready: ready_wb_o = (count < Depth) | retire. Enqueue and retire may occur in the same cycle at full, giving net count unchanged.
- Forwarding (per read port, address != x0):
  - Select the youngest valid entry whose waddr matches and which writes the integer RF.
  - If it is a non-load, or a load already done without err: fwd_valid=1, fwd_data=entry data.
  - If it is a load not yet done: hazard=1, fwd_valid=0.
  - Older matches are shadowed by the youngest match.
- Outstanding flags: outstanding_load_wb_o / outstanding_store_wb_o are OR over valid entries of matching type with done=0.
- Reset:
  - rst_i clears pointers, count and all valid/done bits. All outputs read 0.
  - Loads in flight at reset are dropped; late responses after reset are ignored.
  - Reset overrides same-cycle enqueue and response.

Decomposition:
- ibex_pkg: keep wb_instr_type_e; add wb_entry_t (entry struct, data field sized by a package constant FPU_WIDTH_MAX=64).
- One sub-module, ibex_wb_fwd_lookup: a youngest-match priority search over entries, instantiated per read port. It takes the entry array plus head pointer and returns fwd_valid, fwd_data and hazard.

Test Plan:
1. Depth=2, enqueue OTHER x5/rd=5 data=0xA5, then LOAD x6 -> x5 written 0xA5 next cycle; occupancy 1; hazard_a_o=1 for raddr 6 until the response with data 0x1234 writes x6=0x1234.
2. Enqueue LOAD x1, then OTHER x2=7, then OTHER x3=9 with Depth=2 and no response -> ready_wb_o=0 on the third instruction. A response of 0xBEEF retires x1 the same cycle and ready_wb_o=1; subsequent order is x2 then x3.
3. Enqueue STORE then LOAD x4; response 1 err=1, response 2 data 0x55 -> store retires with perf_instr_ret_wb_o=0; x4=0x55 written with perf=1.
4. Enqueue LOAD with fp_load_i=1, rd=f3, response 0x3F800000 -> fp_rf_we_wb_o=1, fp_rf_waddr_wb_o=3, rf_we_wb_o=0.
5. Two queued writes to x7 (0x11 then 0x22), raddr_b=7 -> fwd_data_b_o=0x22; raddr 0 -> fwd_valid_b_o=0.
6. Assert rst_i with 2 outstanding loads, then pulse lsu_resp_valid_i -> no RF write, occupancy 0, outstanding_load_wb_o=0.
